// File: rtl/seq_div.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient
// bit per clock, start/busy/done handshake. Companion to the sequential multiplier.
module seq_div #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero
);

  localparam int CW = $clog2(2*N+1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e         state_q, state_d;
  logic [2*N-1:0] dvd_q, dvd_d;
  logic [N-1:0]   dvs_q, dvs_d;
  logic [N-1:0]   prem_q, prem_d;
  logic [2*N-1:0] qsh_q, qsh_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] quot_q, quot_d;
  logic [N-1:0]   rem_q, rem_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           dbz_q, dbz_d;

  // One restoring step. The stored partial remainder is always below the
  // divisor, so its top bit is implicit and only the N-bit value is kept.
  logic [N:0]     t;
  logic           ge;
  logic [N:0]     prem_nxt;
  logic [2*N-1:0] qsh_nxt;

  always_comb begin
    t        = {prem_q, dvd_q[2*N-1]};
    ge       = (t >= {1'b0, dvs_q});
    prem_nxt = ge ? (t - {1'b0, dvs_q}) : t;
    qsh_nxt  = {qsh_q[2*N-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    qsh_d   = qsh_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          prem_d  = '0;
          qsh_d   = '0;
          cnt_d   = CW'(2*N);
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        dvd_d  = dvd_q << 1;
        prem_d = prem_nxt[N-1:0];
        qsh_d  = qsh_nxt;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Zero divisor still runs the full latency; result is forced.
          if (dvs_q == '0) begin
            quot_d = '1;
            rem_d  = '0;
            dbz_d  = 1'b1;
          end else begin
            quot_d = qsh_nxt;
            rem_d  = prem_nxt[N-1:0];
            dbz_d  = 1'b0;
          end
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      qsh_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      qsh_q   <= qsh_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: directed vector table, handshake/reset sequences and
// random operands against a plain-arithmetic division model.
module tb_seq_div;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [2*N-1:0] dividend = '0;
  logic [N-1:0]   divisor = '0;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  logic           busy, done, div_by_zero;

  seq_div #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*N-1:0] a;
    logic [N-1:0]   b;
    logic [2*N-1:0] q;
    logic [N-1:0]   r;
    logic           z;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  logic [2*N-1:0] prev_q = '0;
  logic [N-1:0]   prev_r = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic start_op(input logic [2*N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts rising edges until done is seen (0 if the budget runs out).
  task automatic wait_done(input int max, output int lat);
    lat = 0;
    for (int k = 1; k <= max; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
  endtask

  task automatic run_check(input string tag, input logic [2*N-1:0] a, input logic [N-1:0] b,
                           input logic [2*N-1:0] eq, input logic [N-1:0] er, input logic ez);
    int lat;
    start_op(a, b);
    chk({tag, " busy after accept"}, busy, 1);
    chk({tag, " quotient held on start"}, quotient, prev_q);
    wait_done(20, lat);
    chk({tag, " latency"}, lat, 2*N);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " div_by_zero"}, div_by_zero, ez);
    chk({tag, " busy at done"}, busy, 0);
    @(posedge clk); #1;
    chk({tag, " done one cycle"}, done, 0);
    prev_q = eq; prev_r = er;
  endtask

  initial begin
    vec_t vt[7];
    int lat, lat2;
    logic [2*N-1:0] ra, mq;
    logic [N-1:0] rb, mr;

    vt[0] = '{8'd15,  4'd3,  8'd5,   4'd0, 1'b0};
    vt[1] = '{8'd77,  4'd9,  8'd8,   4'd5, 1'b0};
    vt[2] = '{8'd225, 4'd15, 8'd15,  4'd0, 1'b0};
    vt[3] = '{8'd144, 4'd12, 8'd12,  4'd0, 1'b0};
    vt[4] = '{8'd255, 4'd4,  8'd63,  4'd3, 1'b0};
    vt[5] = '{8'd200, 4'd0,  8'd255, 4'd0, 1'b1};
    vt[6] = '{8'd72,  4'd9,  8'd8,   4'd0, 1'b0};

    // Reset, then idle with outputs at zero.
    repeat (2) @(posedge clk);
    #1;
    chk("reset quotient", quotient, 0);
    chk("reset busy", busy, 0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("idle outputs", {quotient, remainder, busy, done, div_by_zero}, 0);
    end

    for (int i = 0; i < 7; i++)
      run_check($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].z);

    // Start while busy is ignored.
    start_op(8'd15, 4'd3);
    repeat (2) @(posedge clk);
    @(negedge clk); dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("ignored start busy", busy, 1);
    wait_done(20, lat);
    chk("ignored start latency", lat, 2*N - 3);
    chk("ignored start quotient", quotient, 5);
    chk("ignored start remainder", remainder, 0);
    prev_q = 8'd5; prev_r = 4'd0;

    // Start held high: second op accepted in the done cycle.
    @(negedge clk); dividend = 8'd15; divisor = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    chk("held start busy", busy, 1);
    @(negedge clk); dividend = 8'd77; divisor = 4'd9;
    wait_done(20, lat);
    chk("held first latency", lat, 2*N);
    chk("held first quotient", quotient, 5);
    wait_done(20, lat2);
    @(negedge clk); start = 1'b0;
    chk("held done spacing", lat2, 2*N + 1);
    chk("held second quotient", quotient, 8);
    chk("held second remainder", remainder, 5);
    @(posedge clk); #1;
    chk("held stop idle", busy, 0);

    // Reset mid-operation aborts with no done pulse.
    start_op(8'd255, 4'd4);
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort outputs", {quotient, remainder, busy, done, div_by_zero}, 0);
    @(negedge clk); rst = 1'b0;
    wait_done(12, lat);
    chk("abort no done", lat, 0);
    prev_q = '0; prev_r = '0;
    run_check("after abort", 8'd15, 4'd3, 8'd5, 4'd0, 1'b0);

    // Random operands against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
      if (rb == 0) begin mq = '1; mr = '0; end
      else begin mq = ra / {4'd0, rb}; mr = 4'(ra % {4'd0, rb}); end
      run_check($sformatf("rand %0d/%0d", ra, rb), ra, rb, mq, mr, rb == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
